// File: rtl/block_emitter_pkg.sv
// Shared encodings, ASCII constants and letter tables for the block emitter.
// Optional build macro: BLOCK_EMITTER_GUARD_EN (rejects under/overflowing commands).
package block_emitter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORD = 2'd1,
        S_SEP  = 2'd2
    } state_e;

    typedef enum logic {
        CMD_BEGIN = 1'b0,
        CMD_END   = 1'b1
    } cmd_e;

    localparam logic [7:0]  SPACE     = 8'd32;
    localparam logic [7:0]  CASE_OFS  = 8'd32;
    localparam logic [3:0]  DEPTH_MAX = 4'd15;

    // First letter sits in the most significant byte.
    localparam logic [39:0] BEGIN_TXT = "begin";
    localparam logic [23:0] END_TXT   = "end";

    function automatic logic [2:0] word_len(cmd_e c);
        return (c == CMD_BEGIN) ? 3'd5 : 3'd3;
    endfunction

endpackage

// File: rtl/block_emitter_if.sv
// Command handshake and character stream of the block emitter.
// master = command source / stream consumer, slave = the emitter.
interface block_emitter_if;

    logic       cmd_valid;
    logic       cmd;
    logic [4:0] case_mask;
    logic       cmd_ready;
    logic [7:0] out;
    logic       out_valid;
    logic [3:0] depth;
    logic       result;
    logic       err;

    modport master (
        output cmd_valid, cmd, case_mask,
        input  cmd_ready, out, out_valid, depth, result, err
    );

    modport slave (
        input  cmd_valid, cmd, case_mask,
        output cmd_ready, out, out_valid, depth, result, err
    );

endinterface

// File: rtl/block_emitter_char.sv
// Combinational letter lookup: (command, letter index, case bit) -> ASCII byte.
// Indices past the end of the word map to a space.
module block_emitter_char
    import block_emitter_pkg::*;
(
    input  cmd_e       cmd,
    input  logic [2:0] idx,
    input  logic       upper,
    output logic [7:0] ch
);

    logic [7:0] lower;
    logic       in_word;

    assign in_word = (idx < word_len(cmd));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        lower = SPACE;
        if (in_word) begin
            if (cmd == CMD_BEGIN) lower = BEGIN_TXT[8 * (4 - int'(idx)) +: 8];
            else                  lower = END_TXT[8 * (2 - int'(idx)) +: 8];
        end
    end

    assign ch = (in_word && upper) ? lower - CASE_OFS : lower;

endmodule

// File: rtl/block_emitter.sv
// Emits "begin "/"end " character streams on command and tracks nesting depth.
// Build option: define BLOCK_EMITTER_GUARD_EN to reject END at depth 0 and BEGIN at depth 15.
module block_emitter
    import block_emitter_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    block_emitter_if.slave bus
);

    state_e     state_q, state_d;
    cmd_e       cmd_q, cmd_d, cmd_sel;
    logic [4:0] mask_q, mask_d, mask_sel;
    logic [2:0] idx_q, idx_d, idx_sel;
    logic [7:0] out_q, out_d, ch;
    logic       valid_q, valid_d;
    logic [3:0] depth_q, depth_d;
    logic       ovf_q, ovf_d, unf_q, unf_d;
    logic       result_q, err_q;
    logic       ready, accept, reject, start, upper;

    assign ready  = (state_q != S_WORD);
    assign accept = bus.cmd_valid && ready;

`ifdef BLOCK_EMITTER_GUARD_EN
    assign reject = accept && (bus.cmd ? (depth_q == 4'd0) : (depth_q == DEPTH_MAX));
`else
    assign reject = 1'b0;
`endif

    assign start = accept && !reject;

    // On accept the first letter is looked up from the live command, afterwards from the registered one.
    assign cmd_sel  = start ? cmd_e'(bus.cmd) : cmd_q;
    assign mask_sel = start ? bus.case_mask   : mask_q;
    assign idx_sel  = start ? 3'd0            : idx_q;
    assign upper    = (idx_sel < 3'd5) && mask_sel[idx_sel];

    block_emitter_char u_char (
        .cmd   (cmd_sel),
        .idx   (idx_sel),
        .upper (upper),
        .ch    (ch)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        out_d   = SPACE;
        valid_d = 1'b0;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (start) begin
            state_d = S_WORD;
            cmd_d   = cmd_sel;
            mask_d  = mask_sel;
            idx_d   = 3'd1;
            out_d   = ch;
            valid_d = 1'b1;
            if (cmd_sel == CMD_BEGIN) begin
                if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
                else                      depth_d = depth_q + 4'd1;
            end else begin
                if (depth_q == 4'd0) unf_d = 1'b1;
                else                 depth_d = depth_q - 4'd1;
            end
        end else begin
            case (state_q)
                S_WORD: begin
                    valid_d = 1'b1;
                    if (idx_q == word_len(cmd_q)) begin
                        state_d = S_SEP;
                    end else begin
                        out_d = ch;
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= CMD_BEGIN;
            mask_q   <= 5'd0;
            idx_q    <= 3'd0;
            out_q    <= SPACE;
            valid_q  <= 1'b0;
            depth_q  <= 4'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            result_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            result_q <= (depth_d == 4'd0) && !ovf_d && !unf_d;
            err_q    <= reject;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.depth     = depth_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_block_emitter.sv
// Directed self-checking bench for block_emitter, including a behavioural
// block checker fed by the emitted stream.
module tb_block_emitter;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    block_emitter_if bus ();

    block_emitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural block checker: words separated by spaces, case-insensitive.
    logic [39:0] word_buf;
    int          word_cnt;
    int          chk_depth;
    logic        chk_err;

    always @(negedge clk) begin
        if (reset) begin
            word_buf  = '0;
            word_cnt  = 0;
            chk_depth = 0;
            chk_err   = 1'b0;
        end else if (bus.out_valid) begin
            if (bus.out == 8'd32) begin
                if (word_cnt == 5 && word_buf == 40'("begin")) begin
                    chk_depth++;
                end else if (word_cnt == 3 && word_buf[23:0] == 24'("end")) begin
                    if (chk_depth == 0) chk_err = 1'b1;
                    else                chk_depth--;
                end else begin
                    chk_err = 1'b1;
                end
                word_buf = '0;
                word_cnt = 0;
            end else begin
                word_buf = {word_buf[31:0], bus.out | 8'h20};
                word_cnt++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge while the emitter is ready; returns just after the accept edge.
    task automatic issue(input logic c, input logic [4:0] m);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.case_mask = m;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [47:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s out[%0d]", tag, i), 32'(bus.out), 32'(exp[8 * (n - 1 - i) +: 8]));
            check($sformatf("%s valid[%0d]", tag, i), 32'(bus.out_valid), 32'd1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 1'b1;
        bus.case_mask = 5'd0;
        repeat (2) @(negedge clk);
        check("rst out", 32'(bus.out), 32'd32);
        check("rst valid", 32'(bus.out_valid), 32'd0);
        check("rst ready", 32'(bus.cmd_ready), 32'd1);
        check("rst depth", 32'(bus.depth), 32'd0);
        check("rst result", 32'(bus.result), 32'd1);
        check("rst err", 32'(bus.err), 32'd0);
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("idle valid", 32'(bus.out_valid), 32'd0);
        check("idle depth", 32'(bus.depth), 32'd0);

        // BEGIN lowercase, then END chained during the trailing space.
        issue(1'b0, 5'b00000);
        expect_word("begin0", 48'("begin "), 6);
        check("begin0 depth", 32'(bus.depth), 32'd1);
        check("begin0 result", 32'(bus.result), 32'd0);
        check("sep ready", 32'(bus.cmd_ready), 32'd1);
        issue(1'b1, 5'b00001);
        expect_word("end1", 48'("End "), 4);
        check("end1 depth", 32'(bus.depth), 32'd0);
        check("end1 result", 32'(bus.result), 32'd1);
        @(negedge clk);
        check("back idle out", 32'(bus.out), 32'd32);
        check("back idle valid", 32'(bus.out_valid), 32'd0);

        // Alternating case mask.
        issue(1'b0, 5'b10101);
        expect_word("begin_mix", 48'("BeGiN "), 6);
        issue(1'b1, 5'b00000);
        expect_word("end_lc", 48'("end "), 4);
        check("mix depth", 32'(bus.depth), 32'd0);

        // Reset while the 3rd letter is on out aborts the word.
        @(negedge clk);
        issue(1'b0, 5'b00000);
        expect_word("abort", 48'("beg"), 3);
        check("abort ready", 32'(bus.cmd_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort out", 32'(bus.out), 32'd32);
        check("abort valid", 32'(bus.out_valid), 32'd0);
        check("abort depth", 32'(bus.depth), 32'd0);
        check("abort ready2", 32'(bus.cmd_ready), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort quiet", 32'(bus.out_valid), 32'd0);

        // Loopback into the checker model: BEGIN, BEGIN, END, END.
        do_reset();
        issue(1'b0, 5'b00011);
        expect_word("lb0", 48'("BEgin "), 6);
        issue(1'b0, 5'b00000);
        expect_word("lb1", 48'("begin "), 6);
        check("lb depth2", 32'(bus.depth), 32'd2);
        issue(1'b1, 5'b00111);
        expect_word("lb2", 48'("END "), 4);
        issue(1'b1, 5'b00000);
        expect_word("lb3", 48'("end "), 4);
        check("lb emitter result", 32'(bus.result), 32'd1);
        @(negedge clk);
        check("lb checker depth", 32'(chk_depth), 32'd0);
        check("lb checker result", 32'((chk_depth == 0) && !chk_err), 32'd1);

        // END at depth 0.
`ifdef BLOCK_EMITTER_GUARD_EN
        issue(1'b1, 5'b00000);
        @(negedge clk);
        check("unf err", 32'(bus.err), 32'd1);
        check("unf out", 32'(bus.out), 32'd32);
        check("unf valid", 32'(bus.out_valid), 32'd0);
        check("unf depth", 32'(bus.depth), 32'd0);
        @(negedge clk);
        check("unf err drop", 32'(bus.err), 32'd0);
        check("unf result", 32'(bus.result), 32'd1);
`else
        issue(1'b1, 5'b00000);
        expect_word("unf", 48'("end "), 4);
        check("unf depth", 32'(bus.depth), 32'd0);
        check("unf result", 32'(bus.result), 32'd0);
        check("unf err", 32'(bus.err), 32'd0);
        issue(1'b0, 5'b00000);
        expect_word("unf_b", 48'("begin "), 6);
        issue(1'b1, 5'b00000);
        expect_word("unf_e", 48'("end "), 4);
        check("unf sticky depth", 32'(bus.depth), 32'd0);
        check("unf sticky result", 32'(bus.result), 32'd0);
`endif
        do_reset();
        check("post rst result", 32'(bus.result), 32'd1);

        // Depth saturation at 15.
        for (int k = 0; k < 15; k++) begin
            issue(1'b0, 5'b00000);
            repeat (6) @(negedge clk);
        end
        check("sat depth15", 32'(bus.depth), 32'd15);
`ifdef BLOCK_EMITTER_GUARD_EN
        issue(1'b0, 5'b00000);
        @(negedge clk);
        check("ovf err", 32'(bus.err), 32'd1);
        check("ovf valid", 32'(bus.out_valid), 32'd0);
        check("ovf depth", 32'(bus.depth), 32'd15);
`else
        issue(1'b0, 5'b00000);
        expect_word("ovf", 48'("begin "), 6);
        check("ovf depth", 32'(bus.depth), 32'd15);
        check("ovf result", 32'(bus.result), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_emitter.md
BLOCK_EMITTER -- requirements
Module: block_emitter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port cmd_valid, input, 1, command request.
REQ-004 SHALL have port cmd, input, 1, command type: 0 = BEGIN word, 1 = END word.
REQ-005 SHALL have port case_mask, input, 5, per-letter uppercase select: bit i = 1 makes letter i uppercase; END uses bits [2:0] only.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready on a clk edge.
REQ-007 SHALL have port out, output, 8, ASCII character stream, one character per cycle, compatible with the block checker's in port.
REQ-008 SHALL have port out_valid, output, 1, high while out carries an emitted character.
REQ-009 SHALL have port depth, output, 4, current begin/end nesting depth.
REQ-010 SHALL have port result, output, 1, high when depth == 0 and no sticky error is set.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on a rejected command (guard builds only).

Function
REQ-012 SHALL use three states: IDLE, WORD (letters), SEP (trailing space).
REQ-013 SHALL drive cmd_ready high in IDLE and in SEP, and low in WORD.
REQ-014 SHALL, on accept, register the command and mask; the first letter appears on out the next cycle (latency 1).
REQ-015 SHALL emit BEGIN as b,e,g,i,n then space (32), one per cycle, 6 cycles total.
REQ-016 SHALL emit END as e,n,d then space, 4 cycles total.
REQ-017 SHALL form uppercase as lowercase minus 32 when the mask bit is set (e.g. 'b'=98 becomes 'B'=66).
REQ-018 SHALL allow an accept during SEP so the next word starts on the following cycle with no gap.
REQ-019 SHALL return to IDLE after SEP when no command is accepted.
REQ-020 SHALL drive out = 32 (space) and out_valid = 0 in IDLE.
REQ-021 SHALL update depth in the accept cycle: BEGIN increments, END decrements.
REQ-022 SHALL saturate depth at 15 on BEGIN and set the sticky flag ovf.
REQ-023 SHALL, without the guard, still emit an END at depth 0, hold depth at 0, and set the sticky flag unf.
REQ-024 SHALL compute result = (depth == 0) && !ovf && !unf as a registered value.

Reset
REQ-025 SHALL, with reset high, force state = IDLE, out = 32, out_valid = 0, cmd_ready = 1, depth = 0, result = 1, err = 0, and clear ovf/unf.
REQ-026 SHALL abort any in-progress word when reset asserts mid-word; no further letters of that word are emitted.
REQ-027 SHALL ignore cmd_valid in the cycle reset is high.

Configuration
REQ-028 SHALL, when BLOCK_EMITTER_GUARD_EN is defined, reject END at depth 0 and BEGIN at depth 15: nothing is emitted, state and depth are unchanged, and err pulses for 1 cycle.
REQ-029 SHALL, when BLOCK_EMITTER_GUARD_EN is undefined, tie err to 0 and apply REQ-022/REQ-023.

Structure
REQ-030 SHALL place the following in a shared package: state encoding, command encoding, ASCII constants (SPACE=32, CASE_OFS=32), and the letter tables "begin"/"end".
REQ-031 SHALL use one sub-module, block_emitter_char, mapping (cmd, letter index, case bit) to an ASCII byte; it is combinational.

Verification
REQ-032 Reset, then BEGIN with mask 00000 -> out = 98,101,103,105,110,32 on cycles 1-6 after accept; depth = 1; result = 0.
REQ-033 Back-to-back: END with mask 001 accepted during SEP -> out = 69,110,100,32 with no idle cycle; depth = 0; result = 1.
REQ-034 BEGIN with mask 10101 -> out = 66,101,71,105,78,32.
REQ-035 END at depth 0: without guard -> out = 101,110,100,32, unf set, result stuck at 0 until reset; with guard -> err pulses, out stays 32, depth = 0.
REQ-036 Reset asserted on the 3rd letter of BEGIN -> next cycle out = 32, out_valid = 0, depth = 0, cmd_ready = 1.
REQ-037 Loopback: drive out into the block checker for the sequence BEGIN, BEGIN, END, END -> checker result = 1 after the final space; the emitter's result also = 1.
